param_seq_calculator: RTL

Parametrised multi-cycle integer calculator, the successor to the fixed 16-bit switch/button calculator. It supports operand width WIDTH and four ops: ADD, SUB, MUL (shift-add, full 2×WIDTH product) and DIV (restoring, with remainder). A Start/Ready/Done/Ack handshake replaces button-driven state stepping, so the block sits between the input-capture/debounce front end and the display/SSD driver.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/calc_muldiv_core.sv | 88 ++++++++
 rtl/param_seq_calculator.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared op codes, one-hot state encoding and the default operand width
// for the sequential calculator.
package calc_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_EXEC = 3'b010,
        S_DONE = 3'b100
    } state_e;

endpackage

// File: rtl/calc_muldiv_core.sv
// Iterative datapath: shift-add multiplier (LSB first) and restoring divider
// (MSB first), one bit per step, sharing one 2*WIDTH accumulator.
module calc_muldiv_core
    import calc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               last_o,
    output logic [2*WIDTH-1:0] acc_next_o,
    output logic [WIDTH-1:0]   rem_next_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_fits;

    // MUL: upper half accumulates, multiplier bits shift out of the lower half.
    // DIV: lower half holds the dividend shifting out and the quotient shifting in.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift - {1'b0, opnd_q};
    end

    always_comb begin
        acc_d    = acc_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            acc_d    = is_div_i ? {{WIDTH{1'b0}}, a_i} : {{WIDTH{1'b0}}, b_i};
            opnd_d   = is_div_i ? b_i : a_i;
            rem_d    = '0;
            is_div_d = is_div_i;
            cnt_d    = CNT_W'(WIDTH);
        end else if (step_i) begin
            if (is_div_q) begin
                rem_d = div_fits ? div_diff : div_shift;
                acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_fits};
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc_q    <= '0;
            rem_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-step values let the top capture the final result on the last edge.
    assign last_o     = (cnt_q == CNT_W'(1));
    assign acc_next_o = acc_d;
    assign rem_next_o = rem_d[WIDTH-1:0];

endmodule

// File: rtl/param_seq_calculator.sv
// Multi-cycle ADD/SUB/MUL/DIV calculator with Start/Ready/Done/Ack handshake;
// FSM, add/sub path and result registers live here.
module param_seq_calculator
    import calc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ack,
    output logic             Ready,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic [WIDTH-1:0] Remainder,
    output logic             Ovf,
    output logic             DivZero
);

    state_e           state_q, state_d;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d;
    logic             divzero_q, divzero_d;

    logic               accept;
    logic               div_by_zero;
    logic               fast_op;
    logic               finish;
    logic [WIDTH:0]     add_full;
    logic [WIDTH-1:0]   sub_res;
    logic               core_last;
    logic [2*WIDTH-1:0] core_acc;
    logic [WIDTH-1:0]   core_rem;

    calc_muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .Clk        (Clk),
        .Reset      (Reset),
        .load_i     (accept),
        .step_i     (state_q == S_EXEC),
        .is_div_i   (op_e'(Op) == OP_DIV),
        .a_i        (A),
        .b_i        (B),
        .last_o     (core_last),
        .acc_next_o (core_acc),
        .rem_next_o (core_rem)
    );

    // ADD, SUB and divide-by-zero all resolve on the first EXEC edge.
    always_comb begin
        accept      = (state_q == S_IDLE) && Start;
        div_by_zero = (op_q == OP_DIV) && (b_q == '0);
        fast_op     = (op_q == OP_ADD) || (op_q == OP_SUB) || div_by_zero;
        finish      = (state_q == S_EXEC) && (fast_op || core_last);
        add_full    = {1'b0, a_q} + {1'b0, b_q};
        sub_res     = a_q - b_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Start)  state_d = S_EXEC;
            S_EXEC:  if (finish) state_d = S_DONE;
            S_DONE:  if (Ack)    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Ready = (state_q == S_IDLE);
        Busy  = (state_q == S_EXEC);
        Done  = (state_q == S_DONE);
    end

    always_comb begin
        result_d    = result_q;
        result_hi_d = result_hi_q;
        rem_d       = rem_q;
        ovf_d       = ovf_q;
        divzero_d   = divzero_q;
        if (accept) begin
            result_d    = '0;
            result_hi_d = '0;
            rem_d       = '0;
            ovf_d       = 1'b0;
            divzero_d   = 1'b0;
        end else if (finish) begin
            case (op_q)
                OP_ADD: begin
                    result_d = add_full[WIDTH-1:0];
                    ovf_d    = add_full[WIDTH];
                end
                OP_SUB: begin
                    result_d = sub_res;
                    ovf_d    = (a_q < b_q);
                end
                OP_MUL: begin
                    result_d    = core_acc[WIDTH-1:0];
                    result_hi_d = core_acc[2*WIDTH-1:WIDTH];
                    ovf_d       = |core_acc[2*WIDTH-1:WIDTH];
                end
                default: begin
                    if (div_by_zero) begin
                        result_d  = '1;
                        rem_d     = a_q;
                        divzero_d = 1'b1;
                    end else begin
                        result_d = core_acc[WIDTH-1:0];
                        rem_d    = core_rem;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            rem_q       <= '0;
            ovf_q       <= 1'b0;
            divzero_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= op_e'(Op);
                a_q  <= A;
                b_q  <= B;
            end
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            rem_q       <= rem_d;
            ovf_q       <= ovf_d;
            divzero_q   <= divzero_d;
        end
    end

    assign Result    = result_q;
    assign ResultHi  = result_hi_q;
    assign Remainder = rem_q;
    assign Ovf       = ovf_q;
    assign DivZero   = divzero_q;

endmodule
